mem_responder: RTL and testbench

//  Slave end of the memory request interface: samples mem_en/mem_rd_wr/mem_add/mem_data

---
 rtl/mem_resp_pkg.sv | 23 ++
 rtl/mem_resp_pipe.sv | 27 ++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the mem_responder slice.
// Holds the response-pipe entry, the FSM state type and the address check.
package mem_resp_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {INIT, READY} state_t;

  localparam int RD_LATENCY_MAX = 4;

  typedef struct packed {
    logic  valid;
    logic  is_read;
    logic  err;
    word_t data;
  } resp_t;

  // Misaligned, or any address bit above the array range set.
  function automatic logic addr_err(input word_t addr, input int depth_log2);
    return (addr[1:0] != 2'b00) || ((addr >> (depth_log2 + 2)) != '0);
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-length delay line for read/error responses.
// Stage 0 captures on the accept edge; synchronous clear on reset.
module mem_resp_pipe
  import mem_resp_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic  clock,
  input  logic  reset,
  input  resp_t in_entry,
  output resp_t out_entry
);

  resp_t stage [LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_entry;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign out_entry = stage[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: post-reset array init, fixed-latency read returns.
// Define MEM_RESP_STATS_EN to add rd_count/wr_count/err_count outputs.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    RD_LATENCY = 2,
  parameter word_t INIT_VALUE = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_rd_wr,
  input  logic [31:0] mem_add,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        mem_err
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  // The registered output stage supplies one cycle, the pipe supplies the rest.
  localparam int LAT = (RD_LATENCY < 1) ? 1 :
                       (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] init_cnt;
  word_t                 mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx, waddr;
  word_t                 wdata;
  logic                  bad_addr, accept, dropped, mem_we;
  resp_t                 pipe_in, pipe_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    case (state_q)
      INIT:    if (init_cnt == '1) state_d = READY;
      READY:   mem_ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign idx      = mem_add[DEPTH_LOG2+1:2];
  assign bad_addr = addr_err(mem_add, DEPTH_LOG2);
  assign accept   = mem_en & mem_ready;
  assign dropped  = mem_en & ~mem_ready;

  // Init sweep and accepted good writes share the single write port.
  assign mem_we = ~reset & ((state_q == INIT) | (accept & ~mem_rd_wr & ~bad_addr));
  assign waddr  = (state_q == INIT) ? init_cnt : idx;
  assign wdata  = (state_q == INIT) ? INIT_VALUE : mem_data;

  always_ff @(posedge clock) begin
    if (mem_we) mem[waddr] <= wdata;
  end

  always_comb begin
    pipe_in         = '0;
    pipe_in.valid   = mem_en;
    pipe_in.is_read = mem_rd_wr;
    pipe_in.err     = dropped | (accept & bad_addr);
    if (accept & mem_rd_wr & ~bad_addr) pipe_in.data = mem[idx];
  end

  mem_resp_pipe #(.LATENCY(LAT)) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_entry  (pipe_in),
    .out_entry (pipe_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      mem_err  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pipe_out.valid & pipe_out.is_read;
      mem_err  <= pipe_out.valid & pipe_out.err;
      if (pipe_out.valid & pipe_out.is_read) rd_data <= pipe_out.data;
    end
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (accept & ~bad_addr & mem_rd_wr)  rd_count  <= rd_count + 32'd1;
      if (accept & ~bad_addr & ~mem_rd_wr) wr_count  <= wr_count + 32'd1;
      if (pipe_out.valid & pipe_out.err)   err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural memory/response model.
module tb_mem_responder;

  localparam int L = 2;

  logic        clock = 1'b0;
  logic        reset, mem_en, mem_rd_wr;
  logic [31:0] mem_add, mem_data;
  logic        mem_ready, rd_valid, mem_err;
  logic [31:0] rd_data;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] rd_count, wr_count, err_count;
`endif

  mem_responder #(.DEPTH_LOG2(10), .RD_LATENCY(L), .INIT_VALUE(32'h0)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_en    (mem_en),
    .mem_rd_wr (mem_rd_wr),
    .mem_add   (mem_add),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_err   (mem_err)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_count (err_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    bit          rd;
    bit          err;
    logic [31:0] data;
  } ev_t;

  ev_t         q[$];
  logic [31:0] mem_m [1024];
  logic [31:0] exp_data;
  int          cyc, init_edges, total, bad;
  int          n_rd, n_wr, n_err;
  bit          m_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
      else begin
        bad++;
        $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
      end
  endtask

  // One clock: drive inputs, advance the model on the edge, then compare outputs.
  task automatic step(input logic rst, input logic en, input logic rw,
                      input logic [31:0] addr, input logic [31:0] data);
    ev_t ev;
    bit  e, exp_v, exp_e;
    @(negedge clock);
    reset = rst; mem_en = en; mem_rd_wr = rw; mem_add = addr; mem_data = data;
    @(posedge clock);
    cyc++;
    if (rst) begin
      q.delete();
      m_ready = 0; init_edges = 0; exp_data = 0;
      foreach (mem_m[i]) mem_m[i] = 32'h0;
      n_rd = 0; n_wr = 0; n_err = 0;
    end else begin
      if (en) begin
        e = !m_ready || (addr % 4 != 0) || (addr >= 32'h1000);
        ev.due  = cyc + L;
        ev.rd   = rw;
        ev.err  = e;
        ev.data = (rw && !e) ? mem_m[addr[11:2]] : 32'h0;
        if (!rw && !e) mem_m[addr[11:2]] = data;
        if (m_ready && !e) begin
          if (rw) n_rd++; else n_wr++;
        end
        q.push_back(ev);
      end
      if (!m_ready) begin
        init_edges++;
        if (init_edges == 1024) m_ready = 1;
      end
    end
    #1;
    exp_v = 0; exp_e = 0;
    while (q.size() > 0 && q[0].due == cyc) begin
      ev = q.pop_front();
      if (ev.rd) begin exp_v = 1; exp_data = ev.data; end
      if (ev.err) begin exp_e = 1; n_err++; end
    end
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, exp_v});
    chk("mem_err", {31'b0, mem_err}, {31'b0, exp_e});
    chk("rd_data", rd_data, exp_data);
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, m_ready});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(0, 1, 1, a, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(0, 1, 0, a, d);
  endtask

  int          wait_cnt;
  logic [31:0] ra;
  int          sel;

  initial begin
    total = 0; bad = 0; cyc = 0;
    reset = 1; mem_en = 0; mem_rd_wr = 0; mem_add = 0; mem_data = 0;

    // Reset, then count cycles to mem_ready; a write during init must be dropped.
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    wait_cnt = 0;
    for (int i = 0; i < 2000 && !mem_ready; i++) begin
      if (i == 5) step(0, 1, 0, 32'h0, 32'h1234);
      else        step(0, 0, 0, 32'h0, 32'h0);
      wait_cnt++;
    end
    chk("ready_cycle", wait_cnt, 32'd1024);
    rd(32'h0); rd(32'hFFC); idle(L);
    chk("init_word0", rd_data, 32'h0);

    // Write then immediate read of the same word.
    wr(32'h10, 32'hDEADBEEF); rd(32'h10); idle(L);
    chk("raw_data", rd_data, 32'hDEADBEEF);

    // Back-to-back reads keep order.
    wr(32'h0, 32'd1); wr(32'h4, 32'd2); wr(32'h8, 32'd3);
    rd(32'h0); rd(32'h4); rd(32'h8); idle(L + 1);

    // Misaligned read and out-of-range write; word 0 must stay intact.
    rd(32'h2); wr(32'h1000, 32'hBAD0BAD0); idle(L);
    rd(32'h0); idle(L);
    chk("no_alias_write", rd_data, 32'd1);

    // Reset with two reads in flight: nothing may come out afterwards.
    rd(32'h4); rd(32'h8);
    step(1, 0, 0, 32'h0, 32'h0);
    chk("flush_rd_data", rd_data, 32'h0);
    for (int i = 0; i < 1100 && !mem_ready; i++) step(0, 0, 0, 32'h0, 32'h0);
    chk("reinit_ready", {31'b0, mem_ready}, 32'd1);

    // Stats: 3 good reads, 2 good writes, 1 error.
    wr(32'h20, 32'hA5A5A5A5); wr(32'h24, 32'h5A5A5A5A);
    rd(32'h20); rd(32'h24); rd(32'h28);
    rd(32'h21); idle(L + 1);
`ifdef MEM_RESP_STATS_EN
    chk("rd_count_dir", rd_count, 32'd3);
    chk("wr_count_dir", wr_count, 32'd2);
    chk("err_count_dir", err_count, 32'd1);
`endif

    // Random traffic with mostly-aligned addresses in a small hot region.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      ra = {20'h0, $urandom_range(0, 1023) % 1024 == 0 ? 10'd0 : 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
      else if (sel == 1) ra = 32'h1000 + ($urandom & 32'h0FFF_FFFC) | ({$urandom} & 32'hF000_0000);
      else if (sel < 7)  ra = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      else               ra = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      step(0, ($urandom % 4) != 0, $urandom % 2 == 1, ra, $urandom);
    end
    idle(L + 1);
`ifdef MEM_RESP_STATS_EN
    chk("rd_count_rand", rd_count, n_rd);
    chk("wr_count_rand", wr_count, n_wr);
    chk("err_count_rand", err_count, n_err);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
